// File: rtl/hemaia_mem_to_axi_pkg.sv
// Shared types for the memory-request to AXI4 master bridge: response-order tags,
// AXI field defaults and the wide AXI request/response structs.
package hemaia_mem_to_axi_pkg;

  localparam int unsigned AXI_ADDR_W = 48;
  localparam int unsigned AXI_DATA_W = 512;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_USER_W = 1;

  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } resp_type_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic [AXI_USER_W-1:0] user;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_wide_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    axi_b_t  b;
    logic    r_valid;
    axi_r_t  r;
  } axi_wide_rsp_t;

endpackage

// File: rtl/hemaia_mem_to_axi_wr_issue.sv
// Write-side issue tracker: raises AW and W independently, remembers which one has
// already handshaken, and grants the memory request once both have completed.
module hemaia_mem_to_axi_wr_issue (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_req,
  input  logic i_full,
  input  logic i_aw_ready,
  input  logic i_w_ready,
  output logic o_aw_valid,
  output logic o_w_valid,
  output logic o_gnt
);

  logic r_aw_done;
  logic r_w_done;
  logic w_active;
  logic w_aw_fin;
  logic w_w_fin;

  // A half-finished write keeps going even when the order FIFO has filled up.
  assign w_active   = i_req && (!i_full || r_aw_done || r_w_done);
  assign o_aw_valid = w_active && !r_aw_done;
  assign o_w_valid  = w_active && !r_w_done;
  assign w_aw_fin   = r_aw_done || (o_aw_valid && i_aw_ready);
  assign w_w_fin    = r_w_done || (o_w_valid && i_w_ready);
  assign o_gnt      = w_active && w_aw_fin && w_w_fin;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (o_gnt) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_aw_done <= w_aw_fin;
      r_w_done  <= w_w_fin;
    end
  end

endmodule

// File: rtl/hemaia_mem_to_axi.sv
// Memory req/gnt/rvalid to AXI4 master bridge with in-order responses.
// Optional error counter: define HEMAIA_MEM_TO_AXI_ERR_CNT_EN.
module hemaia_mem_to_axi
  import hemaia_mem_to_axi_pkg::*;
#(
  parameter type         axi_req_t      = axi_wide_req_t,
  parameter type         axi_rsp_t      = axi_wide_rsp_t,
  parameter int unsigned AddrWidth      = AXI_ADDR_W,
  parameter int unsigned DataWidth      = AXI_DATA_W,
  parameter int unsigned AxiId          = 0,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output logic                   busy_o,
  output axi_req_t               axi_req_o,
  input  axi_rsp_t               axi_rsp_i,
  output logic [15:0]            err_cnt_o
);

  localparam int unsigned OffW    = $clog2(DataWidth / 8);
  localparam int unsigned PtrW    = $clog2(MaxOutstanding);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [2:0]  AxiSize = 3'(OffW);

  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_cnt;
  resp_type_e           r_fifo [MaxOutstanding];
  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;

  logic                 w_full;
  logic                 w_empty;
  resp_type_e           w_head;
  logic                 w_rd_issue;
  logic                 w_ar_hs;
  logic                 w_r_ready;
  logic                 w_b_ready;
  logic                 w_r_hs;
  logic                 w_b_hs;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_resp_err;
  logic                 w_wr_gnt;
  logic                 w_aw_valid;
  logic                 w_w_valid;
  logic [AddrWidth-1:0] w_axi_addr;
  logic                 w_unused;

  assign w_full     = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty    = (r_cnt == '0);
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_axi_addr = {mem_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};

  assign w_rd_issue = mem_req_i && !mem_we_i && !w_full;
  assign w_ar_hs    = w_rd_issue && axi_rsp_i.ar_ready;

  hemaia_mem_to_axi_wr_issue u_wr_issue (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_req      (mem_req_i && mem_we_i),
    .i_full     (w_full),
    .i_aw_ready (axi_rsp_i.aw_ready),
    .i_w_ready  (axi_rsp_i.w_ready),
    .o_aw_valid (w_aw_valid),
    .o_w_valid  (w_w_valid),
    .o_gnt      (w_wr_gnt)
  );

  // Only the channel owning the oldest outstanding entry may hand over a response.
  assign w_r_ready  = !w_empty && (w_head == READ);
  assign w_b_ready  = !w_empty && (w_head == WRITE);
  assign w_r_hs     = axi_rsp_i.r_valid && w_r_ready;
  assign w_b_hs     = axi_rsp_i.b_valid && w_b_ready;
  assign w_resp_err = w_r_hs ? axi_rsp_i.r.resp[1] : axi_rsp_i.b.resp[1];

  assign w_push    = w_ar_hs || w_wr_gnt;
  assign w_pop     = w_r_hs || w_b_hs;
  assign mem_gnt_o = w_push;

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID_W'(AxiId);
    axi_req_o.aw.addr  = w_axi_addr;
    axi_req_o.aw.size  = AxiSize;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.aw.cache = AXI_CACHE_DEFAULT;
    axi_req_o.aw_valid = w_aw_valid;
    axi_req_o.w.data   = mem_wdata_i;
    axi_req_o.w.strb   = mem_strb_i;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_w_valid;
    axi_req_o.b_ready  = w_b_ready;
    axi_req_o.ar.id    = AXI_ID_W'(AxiId);
    axi_req_o.ar.addr  = w_axi_addr;
    axi_req_o.ar.size  = AxiSize;
    axi_req_o.ar.burst = AXI_BURST_INCR;
    axi_req_o.ar.cache = AXI_CACHE_DEFAULT;
    axi_req_o.ar_valid = w_rd_issue;
    axi_req_o.r_ready  = w_r_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Tag storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_we_i ? WRITE : READ;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_pop;
      r_err    <= w_pop && w_resp_err;
      if (w_pop) r_rdata <= w_r_hs ? axi_rsp_i.r.data : '0;
    end
  end

  assign mem_rvalid_o = r_rvalid;
  assign mem_rdata_o  = r_rdata;
  assign mem_err_o    = r_err;
  assign busy_o       = !w_empty;

`ifdef HEMAIA_MEM_TO_AXI_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (w_pop && w_resp_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  assign w_unused = ^{mem_addr_i[OffW-1:0], axi_rsp_i.r.id, axi_rsp_i.r.user,
                      axi_rsp_i.r.resp[0], axi_rsp_i.r.last, axi_rsp_i.b.id,
                      axi_rsp_i.b.user, axi_rsp_i.b.resp[0]};

  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((axi_rsp_i.r_valid || axi_rsp_i.b_valid) && w_empty));
  a_r_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi_rsp_i.r_valid |-> axi_rsp_i.r.last);

endmodule
